// File: rtl/i2s_pkg.sv
// Shared I2S constants and types.
//   Frame geometry (256-bit frames, 128 bits per LRCLK half), the transmitter
//   state type, and the phase numbering inside one 4-cycle bit period.
//   The receiver imports the same package so both sides agree on layout.
package i2s_pkg;

  localparam int FRAME_BITS      = 256;
  localparam int HALF_FRAME_BITS = 128;
  localparam int BIT_IDX_W       = 8;

  localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(FRAME_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] PENULT_BIT = BIT_IDX_W'(FRAME_BITS - 2);
  localparam logic [BIT_IDX_W-1:0] HALF_BIT   = BIT_IDX_W'(HALF_FRAME_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

  // Phase of the 4x clock inside one BCLK period.
  localparam logic [1:0] PH_FETCH   = 2'd0;
  localparam logic [1:0] PH_CAPTURE = 2'd1;
  localparam logic [1:0] PH_SHIFT   = 2'd3;

endpackage

// File: rtl/i2s_clk_phase_gen.sv
// Bit-period phase generator.
//   Owns the 2-bit phase counter that splits each BCLK period into four
//   clk cycles, drives the registered BCLK, and decodes the strobes the
//   transmitter uses to fetch, capture and shift.
// Ports:
//   clk        4x BCLK system clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous hold: counter parked at PH_FETCH, BCLK low
//   bclk       registered bit clock, high for phases 2 and 3
//   fetch_next the next cycle is PH_FETCH (lets the caller register read_en)
//   capture    current phase is PH_CAPTURE (RAM data valid this cycle)
//   shift      current phase is PH_SHIFT (next edge is the BCLK falling edge)
module i2s_clk_phase_gen
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bclk,
  output logic fetch_next,
  output logic capture,
  output logic shift
);

  logic [1:0] phase_reg;
  logic [1:0] phase_next;
  logic       bclk_reg;

  always_comb begin
    phase_next = clear ? PH_FETCH : phase_reg + 2'd1;
  end

  // BCLK is derived from the next phase so it changes on the same edge as
  // the counter: phases 2/3 have the MSB set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= PH_FETCH;
      bclk_reg  <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      bclk_reg  <= phase_next[1];
    end
  end

  assign bclk       = bclk_reg;
  assign fetch_next = (phase_next == PH_FETCH);
  assign capture    = !clear && (phase_reg == PH_CAPTURE);
  assign shift      = !clear && (phase_reg == PH_SHIFT);

endmodule

// File: rtl/i2s_msb_transmitter.sv
// MSB-justified I2S/TDM transmitter.
//   Drains 256-bit frames from a circular bit-addressed RAM (address =
//   {frame, bit}) and serialises them with BCLK = clk/4. It follows the
//   writer's newest complete frame; when it has caught up it plays a muted
//   frame instead and pulses underrun_o.
// Ports:
//   clk_x4_i / rst_n_i       clock (4x BCLK) and async active-low reset
//   enable_i                 playback request (level)
//   frames_valid_i           writer has completed at least one frame
//   last_good_frame_idx_i    newest fully written frame slot
//   ram_read_addr_o/_en_o    RAM bit read port (1-cycle latency)
//   ram_read_data_i          RAM read data
//   i2s_bclk_o/_lrclk_o/_data_o  serial output
//   i2s_running_o            high while playing
//   underrun_o               one-cycle pulse when a muted frame is scheduled
module i2s_msb_transmitter
  import i2s_pkg::*;
#(
  parameter int CIRC_BUF_BITS = 3
) (
  input  logic                       clk_x4_i,
  input  logic                       rst_n_i,
  input  logic                       enable_i,
  input  logic                       frames_valid_i,
  input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
  output logic                       ram_read_en_o,
  input  logic                       ram_read_data_i,
  output logic                       i2s_bclk_o,
  output logic                       i2s_lrclk_o,
  output logic                       i2s_data_o,
  output logic                       i2s_running_o,
  output logic                       underrun_o
);

  tx_state_t                  state_reg, state_next;
  logic [CIRC_BUF_BITS-1:0]   read_frame_reg, read_frame_next;
  logic                       mute_reg, mute_next;
  logic [BIT_IDX_W-1:0]       out_bit_reg, out_bit_next;
  logic                       hold_reg, hold_next;
  logic                       data_reg, data_next;
  logic                       lrclk_reg, lrclk_next;
  logic [CIRC_BUF_BITS+7:0]   addr_reg, addr_next;
  logic                       read_en_reg, read_en_next;
  logic                       running_reg, running_next;
  logic                       underrun_reg, underrun_next;
  logic [BIT_IDX_W-1:0]       fetch_bit;

  logic phase_clear;
  logic fetch_next;
  logic capture;
  logic shift;

  assign phase_clear = (state_reg == IDLE);

  i2s_clk_phase_gen u_phase (
    .clk        (clk_x4_i),
    .rst_n      (rst_n_i),
    .clear      (phase_clear),
    .bclk       (i2s_bclk_o),
    .fetch_next (fetch_next),
    .capture    (capture),
    .shift      (shift)
  );

  always_comb begin
    state_next      = state_reg;
    read_frame_next = read_frame_reg;
    mute_next       = mute_reg;
    out_bit_next    = out_bit_reg;
    hold_next       = hold_reg;
    data_next       = data_reg;
    lrclk_next      = lrclk_reg;
    addr_next       = addr_reg;
    read_en_next    = 1'b0;
    underrun_next   = 1'b0;
    fetch_bit       = '0;

    case (state_reg)
      IDLE: begin
        hold_next  = 1'b0;
        data_next  = 1'b0;
        lrclk_next = 1'b0;
        if (enable_i && frames_valid_i) begin
          state_next      = RUN;
          read_frame_next = last_good_frame_idx_i;
          mute_next       = 1'b0;
          // Dummy bit 255 first, so the first fetch lands on bit 0 and
          // bit 0 reaches the pin together with the LRCLK rising edge.
          out_bit_next    = LAST_BIT;
        end
      end

      RUN: begin
        if (capture) begin
          hold_next = mute_reg ? 1'b0 : ram_read_data_i;
        end
        if (shift) begin
          out_bit_next = out_bit_reg + 8'd1;
          data_next    = hold_reg;
          lrclk_next   = (out_bit_next < HALF_BIT);
          // Frame decision when bit 255 starts: the coming fetch is bit 0
          // of the next frame.
          if (out_bit_reg == PENULT_BIT) begin
            if (read_frame_reg != last_good_frame_idx_i) begin
              read_frame_next = read_frame_reg + CIRC_BUF_BITS'(1);
              mute_next       = 1'b0;
            end else begin
              mute_next       = 1'b1;
              underrun_next   = 1'b1;
            end
          end
          // Stop only on a frame boundary, after bit 255 has been shown.
          if (out_bit_reg == LAST_BIT && !enable_i) begin
            state_next      = IDLE;
            read_frame_next = '0;
            mute_next       = 1'b0;
            out_bit_next    = '0;
            hold_next       = 1'b0;
            data_next       = 1'b0;
            lrclk_next      = 1'b0;
          end
        end
      end
    endcase

    // read_en/addr are registered, so they are prepared on the edge that
    // enters PH_FETCH; the fetched bit is the one after the bit being shown.
    if (state_next == RUN && fetch_next) begin
      read_en_next = !mute_next;
      fetch_bit    = out_bit_next + 8'd1;
      addr_next    = {read_frame_next, fetch_bit};
    end else if (state_next == IDLE) begin
      addr_next = '0;
    end

    running_next = (state_next == RUN);
  end

  always_ff @(posedge clk_x4_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      read_frame_reg <= '0;
      mute_reg       <= 1'b0;
      out_bit_reg    <= '0;
      hold_reg       <= 1'b0;
      data_reg       <= 1'b0;
      lrclk_reg      <= 1'b0;
      addr_reg       <= '0;
      read_en_reg    <= 1'b0;
      running_reg    <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      read_frame_reg <= read_frame_next;
      mute_reg       <= mute_next;
      out_bit_reg    <= out_bit_next;
      hold_reg       <= hold_next;
      data_reg       <= data_next;
      lrclk_reg      <= lrclk_next;
      addr_reg       <= addr_next;
      read_en_reg    <= read_en_next;
      running_reg    <= running_next;
      underrun_reg   <= underrun_next;
    end
  end

  assign ram_read_addr_o = addr_reg;
  assign ram_read_en_o   = read_en_reg;
  assign i2s_data_o      = data_reg;
  assign i2s_lrclk_o     = lrclk_reg;
  assign i2s_running_o   = running_reg;
  assign underrun_o      = underrun_reg;

endmodule

// File: tb/tb_i2s_msb_transmitter.sv
module tb_i2s_msb_transmitter;

  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          frames_valid = 1'b0;
  logic [CB-1:0] last_good = '0;
  logic [CB+7:0] ram_read_addr;
  logic          ram_read_en;
  logic          ram_rdata = 1'b0;
  logic          bclk, lrclk, data, running, underrun;

  logic mem [0:2047];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int start_lg;
    int nframes;
    int adv_mask;        // bit k: last_good advances during frame k
    int exp_first_addr;
    int exp_underruns;   // -1: left to the reference model only
  } scn_t;

  scn_t vec_tbl [7];

  always #5 clk = ~clk;

  i2s_msb_transmitter #(.CIRC_BUF_BITS(CB)) dut (
    .clk_x4_i              (clk),
    .rst_n_i               (rst_n),
    .enable_i              (enable),
    .frames_valid_i        (frames_valid),
    .last_good_frame_idx_i (last_good),
    .ram_read_addr_o       (ram_read_addr),
    .ram_read_en_o         (ram_read_en),
    .ram_read_data_i       (ram_rdata),
    .i2s_bclk_o            (bclk),
    .i2s_lrclk_o           (lrclk),
    .i2s_data_o            (data),
    .i2s_running_o         (running),
    .underrun_o            (underrun)
  );

  // RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (ram_read_en === 1'b1) ram_rdata <= mem[ram_read_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {ram_read_addr, ram_read_en, bclk, lrclk, data, running, underrun};
  endfunction

  task automatic run_scenario(input int id, input scn_t sc);
    int          lg;
    int          frame_of [0:8];
    bit          mute_of  [0:8];
    logic [255:0] got_data, exp_data, got_lr, exp_lr;
    int          shape_err, fetch_err, under_cnt, under_total;
    logic        d0, l0, exp_en;
    int          exp_addr;
    logic [11:0] first_exp;

    for (int i = 0; i < 2048; i++) mem[i] = 1'($urandom_range(1, 0));
    for (int i = 0; i < 9; i++) begin frame_of[i] = 0; mute_of[i] = 1'b0; end
    lg = sc.start_lg;
    frame_of[0] = lg;
    under_total = 0;
    got_data = '0; got_lr = '0;
    exp_lr = {{128{1'b0}}, {128{1'b1}}};
    d0 = 1'b0; l0 = 1'b0;

    last_good    = CB'(lg);
    frames_valid = 1'b1;
    enable       = 1'b1;
    tick;
    first_exp = {1'b1, 11'(sc.exp_first_addr)};
    check($sformatf("scn%0d first_fetch", id), 256'({ram_read_en, ram_read_addr}), 256'(first_exp));

    shape_err = 0; fetch_err = 0; under_cnt = 0;
    for (int s = -1; s < sc.nframes * 256; s++) begin
      int k;
      int b;
      k = (s < 0) ? 0 : s / 256;
      b = (s < 0) ? -1 : s % 256;
      // next-frame decision made as bit 255 of frame k starts
      if (b == 255) begin
        if (frame_of[k] != lg) begin
          frame_of[k+1] = (frame_of[k] + 1) % 8;
          mute_of[k+1]  = 1'b0;
        end else begin
          frame_of[k+1] = frame_of[k];
          mute_of[k+1]  = 1'b1;
        end
      end
      for (int ph = 0; ph < 4; ph++) begin
        if (s >= 0 || ph > 0) tick;
        if (bclk !== (ph >= 2) || running !== 1'b1) shape_err++;
        if (ph == 0) begin
          d0 = data; l0 = lrclk;
        end else if (data !== d0 || lrclk !== l0) begin
          shape_err++;
        end
        if (s < 0 && (data !== 1'b0 || lrclk !== 1'b0)) shape_err++;
        exp_en = 1'b0; exp_addr = 0;
        if (ph == 0) begin
          if (s < 0) begin
            exp_en = 1'b1; exp_addr = frame_of[0] * 256;
          end else if (b < 255) begin
            exp_en = !mute_of[k]; exp_addr = frame_of[k] * 256 + b + 1;
          end else begin
            exp_en = !mute_of[k+1]; exp_addr = frame_of[k+1] * 256;
          end
        end
        if (ram_read_en !== exp_en || (exp_en && ram_read_addr !== 11'(exp_addr))) fetch_err++;
        if (underrun === 1'b1) under_cnt++;
        if (underrun !== (b == 255 && ph == 0 && mute_of[k+1])) fetch_err++;
        if (s >= 0 && ph == 2) begin
          got_data[b] = data;
          got_lr[b]   = lrclk;
        end
        if (b == 64 && ph == 0 && ((sc.adv_mask >> k) & 1) == 1) begin
          lg = (lg + 1) % 8;
          last_good = CB'(lg);
        end
        if (s == (sc.nframes - 1) * 256 + 40 && ph == 1) enable = 1'b0;
      end
      if (b == 255) begin
        for (int bb = 0; bb < 256; bb++)
          exp_data[bb] = mute_of[k] ? 1'b0 : mem[frame_of[k] * 256 + bb];
        $display("scn %0d frame %0d slot %0d mute %0d underrun_next %0d",
                 id, k, frame_of[k], mute_of[k], mute_of[k+1]);
        check($sformatf("scn%0d f%0d data", id, k), got_data, exp_data);
        check($sformatf("scn%0d f%0d lrclk", id, k), got_lr, exp_lr);
        check($sformatf("scn%0d f%0d shape_errs", id, k), 256'(shape_err), '0);
        check($sformatf("scn%0d f%0d fetch_errs", id, k), 256'(fetch_err), '0);
        check($sformatf("scn%0d f%0d underruns", id, k), 256'(under_cnt), 256'(mute_of[k+1]));
        under_total += under_cnt;
        shape_err = 0; fetch_err = 0; under_cnt = 0;
      end
    end
    tick;
    check($sformatf("scn%0d stop_idle", id), 256'(outs()), '0);
    if (sc.exp_underruns >= 0)
      check($sformatf("scn%0d underrun_total", id), 256'(under_total), 256'(sc.exp_underruns));
    enable = 1'b0;
  endtask

  initial begin
    // start, frames, advance mask, first addr, underruns
    vec_tbl[0] = '{5, 4, 'b1111, 'h500, 0};  // 5->6->7->0 wrap
    vec_tbl[1] = '{5, 4, 'b1101, 'h500, 1};  // stall at 6, then 0x700
    vec_tbl[2] = '{0, 2, 'b0000, 'h000, 2};  // never advances
    vec_tbl[3] = '{7, 3, 'b0111, 'h700, 0};  // 7->0->1
    for (int i = 4; i < 7; i++) begin
      vec_tbl[i].start_lg       = int'($urandom_range(7, 0));
      vec_tbl[i].nframes        = 3;
      vec_tbl[i].adv_mask       = int'($urandom_range(7, 0));
      vec_tbl[i].exp_first_addr = vec_tbl[i].start_lg * 256;
      vec_tbl[i].exp_underruns  = -1;
    end
    for (int i = 0; i < 2048; i++) mem[i] = 1'($urandom_range(1, 0));

    #1;
    check("reset_values", 256'(outs()), '0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    check("idle_after_reset", 256'(outs()), '0);

    // enable without a valid frame must stay idle
    enable = 1'b1; frames_valid = 1'b0;
    tick; tick; tick;
    check("no_valid_idle", 256'(outs()), '0);

    // asynchronous reset in the middle of a run (bit 5, phase 2)
    last_good = 3'd2; frames_valid = 1'b1;
    tick;
    for (int n = 0; n < 26; n++) tick;
    check("pre_reset_running", 256'({running, bclk, lrclk}), 256'(3'b111));
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 256'(outs()), '0);
    tick;
    rst_n = 1'b1; enable = 1'b0; frames_valid = 1'b0;
    tick; tick;
    check("post_reset_idle", 256'(outs()), '0);

    for (int i = 0; i < 7; i++) run_scenario(i, vec_tbl[i]);

    for (int n = 0; n < 8; n++) tick;
    check("idle_hold", 256'(outs()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_msb_transmitter.md
# i2s_msb_transmitter

Serialises 256-bit audio frames from a circular bit-addressed RAM onto an MSB-justified I2S/TDM output, generating BCLK and LRCLK from a 4x clock. It is the playback-side counterpart of the I2S MSB receiver. The receiver fills the RAM from the ADAT/I2S side. This block drains a RAM that the USB side fills, following the writer's last-complete-frame index.

## Interface
- CIRC_BUF_BITS, 3, log2 of frame slots in RAM. Address = {frame, bit[7:0]}.
- clk_x4_i  in  1  system clock, 4x BCLK.
- rst_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  request playback. Level-sensitive.
- frames_valid_i  in  1  writer has completed at least one frame. Synchronous to clk_x4_i.
- last_good_frame_idx_i  in  CIRC_BUF_BITS  newest fully written frame slot. Synchronous to clk_x4_i.
- ram_read_addr_o  out  CIRC_BUF_BITS+8  RAM bit address.
- ram_read_en_o  out  1  RAM read strobe. The RAM has 1-cycle read latency.
- ram_read_data_i  in  1  RAM read data.
- i2s_bclk_o  out  1  bit clock.
- i2s_lrclk_o  out  1  frame/word clock.
- i2s_data_o  out  1  serial data.
- i2s_running_o  out  1  high while in RUN.
- underrun_o  out  1  one-cycle pulse when a muted frame is scheduled.

## Operation
- States: IDLE, RUN.
- IDLE: phase counter held at 0. All I2S outputs are 0 and ram_read_en_o is 0.
- IDLE→RUN occurs when enable_i && frames_valid_i. On entry:
  - read_frame_r <= last_good_frame_idx_i, mute_r <= 0.
  - out_bit_r <= 255 as a dummy bit: data 0, lrclk 0.
- 2-bit phase counter p increments every cycle in RUN.
- One bit period is 4 cycles:
  - p==0: ram_read_en_o=1 and ram_read_addr_o={read_frame_r, out_bit_r+1} (8-bit wrap).
  - p==1: data valid. Capture it into hold_r at the 1→2 edge.
  - 3→0 edge: out_bit_r++, i2s_data_o<=hold_r, i2s_lrclk_o<=(new out_bit_r<128).
- Frame decision happens at the 3→0 edge where out_bit_r becomes 255 (the next fetch is bit 0):
  - If read_frame_r != last_good_frame_idx_i: read_frame_r++ (mod 2^CIRC_BUF_BITS), mute_r<=0.
  - Otherwise (caught up): read_frame_r is held, mute_r<=1, underrun_o pulses for 1 cycle.
- Mute frame: ram_read_en_o stays 0 and hold_r is forced to 0. The lrclk and bclk pattern is unchanged.
- enable_i deasserted in RUN: the current frame finishes. At the 3→0 edge after bit 255 is output, go to IDLE with all outputs 0.
- Asynchronous reset at any time: every register and output goes to 0 immediately, and the state is IDLE.

## Timing
- All outputs are registered.
- i2s_bclk_o=1 for p∈{2,3} and 0 for p∈{0,1}. It is updated on the same edge as p.
- Data and lrclk change only on the BCLK falling edge (p 3→0). The receiver samples them at BCLK rising.
- MSB-justified: bit 0 coincides with the LRCLK rising edge, with no one-bit delay. LRCLK is high for bits 0–127 and low for bits 128–255.
- Fetch-to-output latency: from read_en at p==0 to data on the pin is 4 cycles.
- First real bit (frame bit 0) appears at the 4th rising edge after RUN entry.
- Reset values: all outputs 0.

## Structure
- Shared package i2s_pkg holds:
  - FRAME_BITS=256, HALF_FRAME_BITS=128.
  - state enum tx_state_t {IDLE, RUN}.
  - Phase constants PH_FETCH=0, PH_CAPTURE=1, PH_SHIFT=3.
- The receiver should import the same constants.
- One sub-module, i2s_clk_phase_gen, owns the 2-bit counter, bclk_o, and the fetch/capture/shift strobes. It is held in reset while in IDLE.
- The frame-selection and output logic stays in the top module.

## Test plan
- Reset values: assert rst_n_i low mid-RUN. All outputs must go to 0 asynchronously; after release the block is in IDLE.
- Startup: enable=1, valid=1, last_good=5.
  - First ram_read_addr_o = 0x500.
  - bit 0 = RAM[0x500] appears with lrclk rising.
  - 128 BCLK periods high, then 128 low.
- Steady advance: last_good increments once per frame. Reads must walk frames 5→6→7→0 (wrap with CIRC_BUF_BITS=3) with no underrun_o.
- Underrun: hold last_good=6 while read_frame_r=6.
  - The next frame is all zeros, with no read_en and one underrun_o pulse.
  - After last_good=7, the following frame reads 0x700.
- Stop: drop enable_i at bit 40. Bits 41–255 must still be output; then IDLE, with bclk/lrclk/data at 0.
- BCLK shape: exactly 4 clk_x4 cycles per period at 50% duty. Data transitions only on falling edges.
